// File: rtl/acq_trigger.sv
// rtl/acq_trigger.sv - armed threshold/external/auto trigger that captures one event into a FIFO
//
// Ports:
//   clklvds, rstn          sample clock, asynchronous active-low reset
//   arm, readout_done      levels from the host clock domain, synchronised here
//   trigtype               0 immediate, 1 rising threshold, 2 falling threshold, 3 external
//   lowerthresh/upperthresh signed 12-bit thresholds, latched at arm
//   lengthtotake           FIFO words per event, latched at arm
//   autotrig               armed cycles before a forced trigger, 0 disables
//   trig_sample, ext_trig  trigger sources
//   data_in, fifo_full     capture data and FIFO back-pressure
//   fifo_wr, fifo_din      registered FIFO write port
//   trig_count, event_count, auto_fired, acq_state  status / debug
module acq_trigger #(
    parameter int DATA_W      = 560,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clklvds,
    input  logic                rstn,
    input  logic                arm,
    input  logic                readout_done,
    input  logic [1:0]          trigtype,
    input  logic signed [11:0]  lowerthresh,
    input  logic signed [11:0]  upperthresh,
    input  logic [15:0]         lengthtotake,
    input  logic [15:0]         autotrig,
    input  logic signed [11:0]  trig_sample,
    input  logic                ext_trig,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DATA_W-1:0]   fifo_din,
    output logic [15:0]         trig_count,
    output logic [15:0]         event_count,
    output logic                auto_fired,
    output logic [2:0]          acq_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM1    = 3'd1,
        ARM2    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [SYNC_STAGES-1:0]    arm_sync_q, arm_sync_d;
    logic [SYNC_STAGES-1:0]    done_sync_q, done_sync_d;
    logic [1:0]                type_q, type_d;
    logic signed [11:0]        lower_q, lower_d;
    logic signed [11:0]        upper_q, upper_d;
    logic [15:0]               len_q, len_d;
    logic [15:0]               to_cnt_q, to_cnt_d;
    logic                      auto_fired_q, auto_fired_d;
    logic                      fifo_wr_q, fifo_wr_d;
    logic [DATA_W-1:0]         fifo_din_q, fifo_din_d;
    logic [15:0]               trig_count_q, trig_count_d;
    logic [15:0]               event_count_q, event_count_d;

    logic arm_s;
    logic done_s;
    logic below_low;
    logic above_up;
    logic auto_hit;
    logic fire;
    logic advance;

    assign arm_s  = arm_sync_q[SYNC_STAGES-1];
    assign done_s = done_sync_q[SYNC_STAGES-1];

    // Strict signed compares: a sample equal to a threshold never advances.
    assign below_low = trig_sample < lower_q;
    assign above_up  = trig_sample > upper_q;
    assign auto_hit  = (autotrig != 16'd0) && (to_cnt_q == autotrig - 16'd1);

    // fire: a real trigger that goes straight to CAPTURE this cycle.
    // advance: first half of a threshold crossing (ARM1 -> ARM2).
    always_comb begin
        fire    = 1'b0;
        advance = 1'b0;
        if (state_q == ARM1) begin
            case (type_q)
                2'd1:    advance = below_low;
                2'd2:    advance = above_up;
                2'd3:    fire    = ext_trig;
                default: ;
            endcase
        end else if (state_q == ARM2) begin
            case (type_q)
                2'd1:    fire = above_up;
                2'd2:    fire = below_low;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        arm_sync_d    = (arm_sync_q << 1) | SYNC_STAGES'(arm);
        done_sync_d   = (done_sync_q << 1) | SYNC_STAGES'(readout_done);
        type_d        = type_q;
        lower_d       = lower_q;
        upper_d       = upper_q;
        len_d         = len_q;
        to_cnt_d      = to_cnt_q;
        auto_fired_d  = auto_fired_q;
        fifo_wr_d     = 1'b0;
        fifo_din_d    = fifo_din_q;
        trig_count_d  = trig_count_q;
        event_count_d = event_count_q;

        case (state_q)
            IDLE: begin
                trig_count_d = 16'd0;
                if (arm_s && !done_s) begin
                    type_d       = trigtype;
                    lower_d      = lowerthresh;
                    upper_d      = upperthresh;
                    len_d        = lengthtotake;
                    to_cnt_d     = 16'd0;
                    auto_fired_d = 1'b0;
                    state_d      = (trigtype == 2'd0) ? CAPTURE : ARM1;
                end
            end

            ARM1, ARM2: begin
                to_cnt_d = to_cnt_q + 16'd1;
                if (!arm_s) begin
                    state_d = IDLE;
                end else if (fire) begin
                    state_d = CAPTURE;
                end else if (auto_hit) begin
                    // Timeout beats a half-finished crossing so the forced
                    // trigger is never skipped by an ARM1->ARM2 step.
                    state_d      = CAPTURE;
                    auto_fired_d = 1'b1;
                end else if (advance) begin
                    state_d = ARM2;
                end
            end

            CAPTURE: begin
                if (trig_count_q < len_q) begin
                    // Stall while full; the event is never truncated.
                    if (!fifo_full) begin
                        fifo_wr_d    = 1'b1;
                        fifo_din_d   = data_in;
                        trig_count_d = trig_count_q + 16'd1;
                    end
                end else begin
                    event_count_d = event_count_q + 16'd1;
                    state_d       = DONE;
                end
            end

            DONE: begin
                if (done_s) begin
                    state_d      = IDLE;
                    trig_count_d = 16'd0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            arm_sync_q    <= '0;
            done_sync_q   <= '0;
            type_q        <= 2'd0;
            lower_q       <= 12'sd0;
            upper_q       <= 12'sd0;
            len_q         <= 16'd0;
            to_cnt_q      <= 16'd0;
            auto_fired_q  <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_din_q    <= '0;
            trig_count_q  <= 16'd0;
            event_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            arm_sync_q    <= arm_sync_d;
            done_sync_q   <= done_sync_d;
            type_q        <= type_d;
            lower_q       <= lower_d;
            upper_q       <= upper_d;
            len_q         <= len_d;
            to_cnt_q      <= to_cnt_d;
            auto_fired_q  <= auto_fired_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_din_q    <= fifo_din_d;
            trig_count_q  <= trig_count_d;
            event_count_q <= event_count_d;
        end
    end

    assign fifo_wr     = fifo_wr_q;
    assign fifo_din    = fifo_din_q;
    assign trig_count  = trig_count_q;
    assign event_count = event_count_q;
    assign auto_fired  = auto_fired_q;
    assign acq_state   = state_q;

endmodule

// File: tb/tb_acq_trigger.sv
// tb/tb_acq_trigger.sv - directed self-checking bench for acq_trigger
module tb_acq_trigger;

    localparam int DATA_W = 560;

    logic               clklvds;
    logic               rstn;
    logic               arm;
    logic               readout_done;
    logic [1:0]         trigtype;
    logic signed [11:0] lowerthresh;
    logic signed [11:0] upperthresh;
    logic [15:0]        lengthtotake;
    logic [15:0]        autotrig;
    logic signed [11:0] trig_sample;
    logic               ext_trig;
    logic [DATA_W-1:0]  data_in;
    logic               fifo_full;
    logic               fifo_wr;
    logic [DATA_W-1:0]  fifo_din;
    logic [15:0]        trig_count;
    logic [15:0]        event_count;
    logic               auto_fired;
    logic [2:0]         acq_state;

    int errors = 0;
    int checks = 0;

    acq_trigger #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clklvds      (clklvds),
        .rstn         (rstn),
        .arm          (arm),
        .readout_done (readout_done),
        .trigtype     (trigtype),
        .lowerthresh  (lowerthresh),
        .upperthresh  (upperthresh),
        .lengthtotake (lengthtotake),
        .autotrig     (autotrig),
        .trig_sample  (trig_sample),
        .ext_trig     (ext_trig),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_din     (fifo_din),
        .trig_count   (trig_count),
        .event_count  (event_count),
        .auto_fired   (auto_fired),
        .acq_state    (acq_state)
    );

    initial clklvds = 1'b0;
    always #5 clklvds = ~clklvds;

    task automatic step(input int n);
        repeat (n) @(negedge clklvds);
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mkdata(input int k);
        logic [15:0] w;
        w = 16'(k) ^ 16'hA5C3;
        return {(DATA_W/16){w}};
    endfunction

    // Drop arm, raise readout_done until DONE->IDLE, then clear it again.
    task automatic do_readout();
        arm          = 1'b0;
        readout_done = 1'b1;
        step(3);
        check("readout_idle", acq_state, 3'd0);
        readout_done = 1'b0;
        step(2);
    endtask

    initial begin
        rstn         = 1'b0;
        arm          = 1'b0;
        readout_done = 1'b0;
        trigtype     = 2'd0;
        lowerthresh  = 12'sd0;
        upperthresh  = 12'sd0;
        lengthtotake = 16'd0;
        autotrig     = 16'd0;
        trig_sample  = 12'sd0;
        ext_trig     = 1'b0;
        data_in      = '0;
        fifo_full    = 1'b0;

        // Reset state
        step(2);
        check("rst_state", acq_state, 3'd0);
        check("rst_wr", fifo_wr, 1'b0);
        check("rst_din", fifo_din, '0);
        check("rst_tc", trig_count, 16'd0);
        check("rst_ec", event_count, 16'd0);
        check("rst_af", auto_fired, 1'b0);
        rstn = 1'b1;
        step(1);

        // Immediate trigger, length 5
        trigtype     = 2'd0;
        lengthtotake = 16'd5;
        arm          = 1'b1;
        step(3);
        check("t0_capture", acq_state, 3'd3);
        for (int k = 0; k < 5; k++) begin
            data_in = mkdata(k);
            step(1);
            check("t0_wr", fifo_wr, 1'b1);
            check("t0_din", fifo_din, mkdata(k));
            check("t0_tc", trig_count, 16'(k + 1));
        end
        step(1);
        check("t0_done", acq_state, 3'd4);
        check("t0_wr_end", fifo_wr, 1'b0);
        check("t0_ec", event_count, 16'd1);
        check("t0_tc_hold", trig_count, 16'd5);

        // DONE with arm held high: readout_done returns to IDLE, no rearm while it is high
        readout_done = 1'b1;
        step(3);
        check("rd_idle", acq_state, 3'd0);
        check("rd_tc0", trig_count, 16'd0);
        trigtype     = 2'd1;
        lowerthresh  = -12'sd10;
        upperthresh  = 12'sd10;
        lengthtotake = 16'd2;
        trig_sample  = 12'sd0;
        step(2);
        check("rd_no_rearm", acq_state, 3'd0);
        readout_done = 1'b0;
        step(2);
        check("rd_still_idle", acq_state, 3'd0);
        step(1);
        check("rd_rearm_arm1", acq_state, 3'd1);

        // Rising threshold -10/+10 with samples 0,-11,5,10,11
        step(1);
        check("thr_s0", acq_state, 3'd1);
        trig_sample = -12'sd11;
        step(1);
        check("thr_s_m11", acq_state, 3'd2);
        trig_sample = 12'sd5;
        step(1);
        check("thr_s5", acq_state, 3'd2);
        trig_sample = 12'sd10;
        step(1);
        check("thr_s10_eq", acq_state, 3'd2);
        trig_sample = 12'sd11;
        step(1);
        check("thr_s11", acq_state, 3'd3);
        check("thr_af", auto_fired, 1'b0);
        trig_sample = 12'sd0;
        for (int k = 0; k < 2; k++) begin
            data_in = mkdata(20 + k);
            step(1);
            check("thr_wr", fifo_wr, 1'b1);
            check("thr_din", fifo_din, mkdata(20 + k));
        end
        step(1);
        check("thr_done", acq_state, 3'd4);
        check("thr_ec", event_count, 16'd2);
        do_readout();

        // Auto trigger after 100 armed cycles on a flat signal
        trigtype     = 2'd1;
        autotrig     = 16'd100;
        lengthtotake = 16'd1;
        trig_sample  = 12'sd0;
        arm          = 1'b1;
        step(3);
        check("auto_arm1", acq_state, 3'd1);
        check("auto_af0", auto_fired, 1'b0);
        step(99);
        check("auto_still_armed", acq_state, 3'd1);
        step(1);
        check("auto_capture", acq_state, 3'd3);
        check("auto_af1", auto_fired, 1'b1);
        step(1);
        check("auto_wr", fifo_wr, 1'b1);
        step(1);
        check("auto_done", acq_state, 3'd4);
        check("auto_ec", event_count, 16'd3);
        autotrig = 16'd0;
        do_readout();

        // Falling type: first step above upper, then arm dropped -> IDLE, no event
        trigtype    = 2'd2;
        trig_sample = 12'sd20;
        arm         = 1'b1;
        step(3);
        check("drop_arm1", acq_state, 3'd1);
        step(1);
        check("drop_arm2", acq_state, 3'd2);
        arm = 1'b0;
        step(2);
        check("drop_hold", acq_state, 3'd2);
        step(1);
        check("drop_idle", acq_state, 3'd0);
        check("drop_ec", event_count, 16'd3);
        trig_sample = 12'sd0;

        // Length 8 with fifo_full high in capture cycles 3-5
        trigtype     = 2'd0;
        lengthtotake = 16'd8;
        arm          = 1'b1;
        step(3);
        check("full_capture", acq_state, 3'd3);
        begin
            int nw;
            nw = 0;
            for (int c = 1; c <= 11; c++) begin
                fifo_full = (c >= 3 && c <= 5);
                data_in   = mkdata(100 + c);
                step(1);
                if (!fifo_full) begin
                    nw++;
                    check("full_wr", fifo_wr, 1'b1);
                    check("full_din", fifo_din, mkdata(100 + c));
                end else begin
                    check("full_nowr", fifo_wr, 1'b0);
                end
                check("full_tc", trig_count, 16'(nw));
            end
        end
        fifo_full = 1'b0;
        step(1);
        check("full_done", acq_state, 3'd4);
        check("full_wr_end", fifo_wr, 1'b0);
        check("full_tc8", trig_count, 16'd8);
        check("full_ec", event_count, 16'd4);
        do_readout();

        // event_count wrap, using a length-0 event
        force dut.event_count_q = 16'hFFFF;
        step(1);
        release dut.event_count_q;
        step(1);
        check("wrap_pre", event_count, 16'hFFFF);
        trigtype     = 2'd0;
        lengthtotake = 16'd0;
        arm          = 1'b1;
        step(3);
        check("wrap_capture", acq_state, 3'd3);
        check("wrap_tc0", trig_count, 16'd0);
        step(1);
        check("wrap_done", acq_state, 3'd4);
        check("wrap_nowr", fifo_wr, 1'b0);
        check("wrap_ec", event_count, 16'h0000);
        do_readout();

        // External trigger, then reset in the middle of capture
        trigtype     = 2'd3;
        lengthtotake = 16'd4;
        ext_trig     = 1'b0;
        arm          = 1'b1;
        step(3);
        check("ext_arm1", acq_state, 3'd1);
        step(1);
        check("ext_wait", acq_state, 3'd1);
        ext_trig = 1'b1;
        step(1);
        check("ext_capture", acq_state, 3'd3);
        ext_trig = 1'b0;
        data_in  = mkdata(7);
        step(2);
        check("ext_wr", fifo_wr, 1'b1);
        check("ext_tc", trig_count, 16'd2);
        rstn = 1'b0;
        #1;
        check("mid_rst_wr", fifo_wr, 1'b0);
        check("mid_rst_state", acq_state, 3'd0);
        check("mid_rst_tc", trig_count, 16'd0);
        check("mid_rst_ec", event_count, 16'd0);
        check("mid_rst_din", fifo_din, '0);
        step(2);
        rstn = 1'b1;
        arm  = 1'b0;
        step(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acq_trigger.md
ACQ_TRIGGER -- requirements
Module: acq_trigger

Interface
REQ-001 Parameter DATA_W, default 560, width of packed sample word written to the event FIFO.
REQ-002 Parameter SYNC_STAGES, default 2, flops on each clk-domain control input.
REQ-003 clklvds  in  1  sample clock; all logic on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 arm  in  1  level from clk domain; request to arm for one event.
REQ-006 readout_done  in  1  level from clk domain; host has read the event.
REQ-007 trigtype  in  2  0 immediate, 1 rising threshold, 2 falling threshold, 3 external.
REQ-008 lowerthresh / upperthresh  in  12 each  signed thresholds, sampled at arm.
REQ-009 lengthtotake  in  16  FIFO words per event, sampled at arm.
REQ-010 autotrig  in  16  clklvds cycles before forced trigger; 0 disables.
REQ-011 trig_sample  in  12  signed sample compared against thresholds.
REQ-012 ext_trig  in  1  external trigger, synchronous to clklvds.
REQ-013 data_in  in  DATA_W  packed samples for the current cycle.
REQ-014 fifo_full  in  1  event FIFO write-full.
REQ-015 fifo_wr  out  1  FIFO write strobe.
REQ-016 fifo_din  out  DATA_W  FIFO write data.
REQ-017 trig_count  out  16  words written in current event.
REQ-018 event_count  out  16  completed events.
REQ-019 auto_fired  out  1  last event was triggered by autotrig timeout.
REQ-020 acq_state  out  3  current state encoding, for debug.

Function
REQ-021 States: IDLE=0, ARM1=1, ARM2=2, CAPTURE=3, DONE=4; unused codes SHALL go to IDLE next cycle.
REQ-022 arm and readout_done SHALL pass through SYNC_STAGES flops (arm_s, done_s) before use.
REQ-023 IDLE: fifo_wr=0, trig_count=0; on arm_s=1 and done_s=0 latch trigtype, thresholds, lengthtotake, clear timeout counter and auto_fired, go ARM1 (types 1,2,3) or CAPTURE (type 0).
REQ-024 ARM1, type 1: trig_sample < lowerthresh -> ARM2; type 2: trig_sample > upperthresh -> ARM2; type 3: ext_trig=1 -> CAPTURE directly.
REQ-025 ARM2, type 1: trig_sample > upperthresh -> CAPTURE; type 2: trig_sample < lowerthresh -> CAPTURE.
REQ-026 Comparisons SHALL be signed 12-bit and strict; equality never advances.
REQ-027 In ARM1/ARM2 a 16-bit timeout counter SHALL increment per cycle; when autotrig!=0 and counter reaches autotrig-1 the block SHALL go CAPTURE and set auto_fired=1; a real trigger on the same cycle wins, auto_fired stays 0.
REQ-028 arm_s falling in ARM1/ARM2 SHALL return to IDLE without changing event_count.
REQ-029 CAPTURE, per cycle: if trig_count < latched length and fifo_full=0, fifo_wr=1, fifo_din=data_in registered, trig_count+1.
REQ-030 CAPTURE with fifo_full=1: fifo_wr=0, hold trig_count, stay (stall, no truncation).
REQ-031 CAPTURE with trig_count == latched length: fifo_wr=0, event_count+1 (16-bit wrap), go DONE; length 0 produces an empty event in one cycle.
REQ-032 fifo_wr and fifo_din SHALL be registered: the write lands one clklvds cycle after the decision, data_in sampled in the decision cycle.
REQ-033 DONE: trig_count held at length; on done_s=1 go IDLE; IDLE rearms only after done_s returns to 0.
REQ-034 First CAPTURE cycle SHALL follow the trigger cycle directly (one-cycle trigger latency).

Reset
REQ-035 On rstn low: state IDLE, fifo_wr=0, fifo_din=0, trig_count=0, event_count=0, auto_fired=0, sync flops 0, latched config 0.
REQ-036 Reset mid-CAPTURE SHALL drop fifo_wr within the reset assertion; partial event not counted.

Verification
REQ-037 type 0, length 5, fifo_full=0, arm 1 -> five fifo_wr pulses on consecutive cycles, event_count 0->1, DONE.
REQ-038 type 1, thresh -10/+10, trig_sample 0,-11,5,10,11 -> CAPTURE entered the cycle after sample 11 only.
REQ-039 type 1, autotrig 100, flat samples -> CAPTURE after 100 armed cycles, auto_fired=1.
REQ-040 length 8, fifo_full high cycles 3-5 of capture -> exactly 8 writes, no write while full, trig_count 8.
REQ-041 event_count 16'hFFFF, one more event -> 16'h0000.
REQ-042 DONE with arm held high, readout_done pulsed -> IDLE, no rearm until readout_done low, then ARM1.
